// File: rtl/phy_tx_framer.sv
// phy_tx_framer: serializes ACK/credit/data frames into K-flagged 8-bit symbols under ready/valid
module phy_tx_framer #(
    parameter int         DATA_BYTES = 4,
    parameter logic [7:0] K_CTRL     = 8'hBC,
    parameter logic [7:0] K_SOD      = 8'h3C,
    parameter bit         IDLE_FILL  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [1:0]              comma_sel,
    input  logic [7:0]              comma_header,
    input  logic [8*DATA_BYTES-1:0] flit_data,
    input  logic                    flit_last,
    input  logic                    sym_ready,
    output logic                    sym_valid,
    output logic [7:0]              sym_data,
    output logic                    sym_k,
    output logic                    busy,
    output logic                    done,
    output logic                    packet_done,
    output logic                    start_drop
);
    localparam int IW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES - 1);
    typedef enum logic [1:0] {IDLE, COMMA, HEADER, DATA} state_t;
    state_t                  state_q, state_d;
    logic [1:0]              sel_q;
    logic [7:0]              hdr_q;
    logic [8*DATA_BYTES-1:0] flit_q;
    logic                    last_q;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    init_q, done_q, done_d, pdone_q, pdone_d, drop_q;
    logic                    xfer, is_data;
    assign xfer        = sym_valid & sym_ready;
    assign is_data     = sel_q == 2'd3;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign packet_done = pdone_q;
    assign start_drop  = drop_q;
    // state, byte index and completion pulses; frame fields latch only when a start is taken in IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            pdone_q <= 1'b0;
            drop_q  <= 1'b0;
            sel_q   <= '0;
            hdr_q   <= '0;
            flit_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            init_q  <= 1'b1;
            done_q  <= done_d;
            pdone_q <= pdone_d;
            drop_q  <= start && state_q != IDLE;
            if (start && state_q == IDLE) begin
                sel_q  <= comma_sel;
                hdr_q  <= comma_header;
                flit_q <= flit_data;
                last_q <= flit_last;
            end
        end
    end
    // next state advances only on a symbol transfer, except IDLE which launches on start
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        pdone_d = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = COMMA;
            COMMA:  if (xfer) state_d = HEADER;
            HEADER: if (xfer) begin
                idx_d   = '0;
                state_d = is_data ? DATA : IDLE;
                done_d  = !is_data;
            end
            DATA:   if (xfer) begin
                idx_d   = idx_q == LAST_IDX ? idx_q : idx_q + 1'b1;
                state_d = idx_q == LAST_IDX ? IDLE : DATA;
                done_d  = idx_q == LAST_IDX;
                pdone_d = idx_q == LAST_IDX && last_q;
            end
            default: ;
        endcase
    end
    // symbol presented per state; idle fill is withheld while a start is launching so frames abut
    always_comb begin
        sym_valid = 1'b1;
        sym_k     = 1'b0;
        sym_data  = hdr_q;
        case (state_q)
            IDLE: begin
                sym_valid = IDLE_FILL && init_q && !start;
                sym_data  = init_q ? K_CTRL : 8'h00;
                sym_k     = init_q;
            end
            COMMA: begin
                sym_data = is_data ? K_SOD : K_CTRL;
                sym_k    = 1'b1;
            end
            DATA:    sym_data = flit_q[{idx_q, 3'b000} +: 8];
            default: ;
        endcase
    end
endmodule

// File: tb/tb_phy_tx_framer.sv
// tb_phy_tx_framer: scoreboard bench for phy_tx_framer with directed and random frames
module tb_phy_tx_framer;
    localparam int DB = 4;
    logic          CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [1:0]    comma_sel = '0;
    logic [7:0]    comma_header = '0;
    logic [8*DB-1:0] flit_data = '0;
    logic          flit_last = 1'b0, sym_ready = 1'b1;
    logic          sym_valid, sym_k, busy, done, packet_done, start_drop;
    logic [7:0]    sym_data;

    phy_tx_framer #(.DATA_BYTES(DB)) dut (
        .CLK(CLK), .RST(RST), .start(start), .comma_sel(comma_sel), .comma_header(comma_header),
        .flit_data(flit_data), .flit_last(flit_last), .sym_ready(sym_ready), .sym_valid(sym_valid),
        .sym_data(sym_data), .sym_k(sym_k), .busy(busy), .done(done), .packet_done(packet_done),
        .start_drop(start_drop)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {logic [7:0] d; logic k;} sym_t;
    typedef struct packed {logic pd; logic [7:0] n;} fin_t;
    sym_t exp_q[$];
    fin_t fin_q[$];
    int   errors = 0, checks = 0, cyc = 0, stall_from = 0, stall_len = 0, consumed = 0;
    bit   rdy_rand = 0, drop_now = 0, drop_pipe = 0, rst_prev = 1, stall_chk = 0, stab_prev = 0;
    sym_t prev_sym;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        sym_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_from && cyc < stall_from + stall_len);
        if (stall_chk && cyc >= 4 && cyc <= 6) chk("stall_hold_BE", {24'b0, sym_data}, 32'hBE);
    endtask

    // reference frame: comma, header, then payload bytes LSB-first for DATA
    function automatic void build(input logic [1:0] s, input logic [7:0] h, input logic [8*DB-1:0] f,
                                  output sym_t q[$]);
        q = {};
        q.push_back('{d: (s == 2'd3) ? 8'h3C : 8'hBC, k: 1'b1});
        q.push_back('{d: h, k: 1'b0});
        if (s == 2'd3) for (int i = 0; i < DB; i++) q.push_back('{d: f[8*i +: 8], k: 1'b0});
    endfunction

    task automatic run_frame(input logic [1:0] s, input logic [7:0] h, input logic [8*DB-1:0] f,
                             input logic l, input bit drop, output int lat);
        sym_t q[$];
        build(s, h, f, q);
        foreach (q[i]) exp_q.push_back(q[i]);
        fin_q.push_back('{pd: (s == 2'd3) && l, n: 8'(q.size())});
        start = 1'b1; comma_sel = s; comma_header = h; flit_data = f; flit_last = l; cyc = 0;
        step();
        start = drop; drop_now = drop;
        if (drop) begin
            comma_sel = 2'($urandom); comma_header = 8'($urandom); flit_data = $urandom; flit_last = 1'($urandom);
        end
        step();
        start = 1'b0; drop_now = 1'b0;
        while (!done && cyc < 300) step();
        chk("done_seen", {31'b0, done}, 32'd1);
        lat = cyc;
    endtask

    // monitor: pops expected symbols on transfers and completion records on done
    always @(negedge CLK) begin
        sym_t e;
        fin_t r;
        if (!RST) begin
            if (busy && sym_valid && sym_ready) begin
                chk("sym_avail", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sym_data", {24'b0, sym_data}, {24'b0, e.d});
                    chk("sym_k", {31'b0, sym_k}, {31'b0, e.k});
                    consumed++;
                end
            end
            if (busy && stab_prev) begin
                chk("stall_data", {24'b0, sym_data}, {24'b0, prev_sym.d});
                chk("stall_k", {31'b0, sym_k}, {31'b0, prev_sym.k});
            end
            stab_prev = busy && sym_valid && !sym_ready;
            prev_sym = '{d: sym_data, k: sym_k};
            if (!busy && !rst_prev) begin
                if (start) chk("no_idle_at_launch", {31'b0, sym_valid && sym_ready}, 32'd0);
                else begin
                    chk("idle_valid", {31'b0, sym_valid}, 32'd1);
                    chk("idle_data", {24'b0, sym_data}, 32'hBC);
                    chk("idle_k", {31'b0, sym_k}, 32'd1);
                end
            end
            if (done || packet_done) begin
                chk("done_pending", {31'b0, fin_q.size() != 0 && done}, 32'd1);
                if (fin_q.size() != 0) begin
                    r = fin_q.pop_front();
                    chk("packet_done", {31'b0, packet_done}, {31'b0, r.pd});
                    chk("frame_len", consumed, {24'b0, r.n});
                end
                consumed = 0;
            end
            if (start_drop || drop_pipe) chk("start_drop", {31'b0, start_drop}, {31'b0, drop_pipe});
        end else begin
            consumed = 0;
            stab_prev = 0;
        end
        drop_pipe = drop_now;
        rst_prev = RST;
    end

    initial begin
        int   lat;
        sym_t q[$];
        step(); step();
        chk("rst_valid", {31'b0, sym_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pdone", {31'b0, packet_done}, 32'd0);
        chk("rst_drop", {31'b0, start_drop}, 32'd0);
        chk("rst_data", {24'b0, sym_data}, 32'd0);
        chk("rst_k", {31'b0, sym_k}, 32'd0);
        RST = 1'b0;
        step(); step();
        run_frame(2'd0, 8'h5A, '0, 1'b0, 1'b0, lat);
        chk("ack_latency", lat, 32'd3);
        step(); step();
        run_frame(2'd3, 8'h81, 32'hDEADBEEF, 1'b1, 1'b0, lat);
        chk("data_latency", lat, 32'd7);
        step(); step();
        stall_from = 4; stall_len = 3; stall_chk = 1;
        run_frame(2'd3, 8'h81, 32'hDEADBEEF, 1'b1, 1'b0, lat);
        stall_chk = 0; stall_len = 0;
        chk("stall_latency", lat, 32'd10);
        step(); step(); step();
        run_frame(2'd3, 8'h81, 32'hDEADBEEF, 1'b1, 1'b1, lat);
        chk("drop_latency", lat, 32'd7);
        step(); step(); step();
        run_frame(2'd2, 8'hC3, '0, 1'b0, 1'b0, lat);
        chk("cred1_latency", lat, 32'd3);
        run_frame(2'd3, 8'h42, 32'h01234567, 1'b0, 1'b0, lat);
        chk("b2b_latency", lat, 32'd7);
        step(); step();
        // reset while byte 2 is presented and stalled: only four symbols ever transfer, no done
        build(2'd3, 8'h81, 32'hDEADBEEF, q);
        for (int i = 0; i < 4; i++) exp_q.push_back(q[i]);
        stall_from = 5; stall_len = 1000;
        start = 1'b1; comma_sel = 2'd3; comma_header = 8'h81; flit_data = 32'hDEADBEEF; flit_last = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("midrst_byte2", {24'b0, sym_data}, 32'hAD);
        RST = 1'b1;
        step();
        chk("midrst_valid", {31'b0, sym_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_pdone", {31'b0, packet_done}, 32'd0);
        RST = 1'b0; stall_len = 0;
        repeat (3) begin
            step();
            chk("postrst_no_done", {31'b0, done | packet_done}, 32'd0);
        end
        rdy_rand = 1;
        repeat (40) begin
            run_frame(2'($urandom), 8'($urandom), $urandom, 1'($urandom), $urandom_range(0, 3) == 0, lat);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
        end
        rdy_rand = 0;
        repeat (4) step();
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("fin_q_drained", fin_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phy_tx_framer.md
Name: phy_tx_framer

Overview:
- Sits directly downstream of the TX arbitration buffer and upstream of the 8b10b encoder.
- Takes one arbitration decision at a time (ACK, credit grant 0/1, or a data flit) and serializes it into 8-bit symbols with a K-flag, under ready/valid backpressure from the encoder.
- Signals completion back to the arbiter through `done`, and through `packet_done` at the end of a packet.

Parameters:
- DATA_BYTES, 4: bytes per flit word; flit_data width is 8*DATA_BYTES.
- K_CTRL, 8'hBC: K28.5 comma that opens ACK/credit frames and serves as idle fill.
- K_SOD, 8'h3C: K28.1 start-of-data comma that opens data frames.
- IDLE_FILL, 1: 1 = emit K_CTRL idle symbols while IDLE; 0 = sym_valid low while IDLE.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- start  input  1  one-cycle request from arbiter; frame fields valid in the same cycle
- comma_sel  input  2  frame type: 0 ACK, 1 GRTCRED0, 2 GRTCRED1, 3 DATA
- comma_header  input  8  header byte sent after the comma
- flit_data  input  8*DATA_BYTES  flit payload (DATA only)
- flit_last  input  1  flit is the last of its packet (DATA only)
- sym_ready  input  1  encoder accepts symbol this cycle
- sym_valid  output  1  symbol present
- sym_data  output  8  symbol byte
- sym_k  output  1  symbol is a K-character
- busy  output  1  frame in progress (state != IDLE)
- done  output  1  one-cycle pulse: last symbol of frame accepted
- packet_done  output  1  one-cycle pulse coincident with done for a DATA frame with flit_last=1
- start_drop  output  1  one-cycle pulse: start received while busy, request discarded

Behaviour:
- Reset (RST=1 at a rising edge): state IDLE; sym_valid=0, sym_data=0, sym_k=0, busy=0, done=0, packet_done=0, start_drop=0; latched fields cleared. A reset mid-frame aborts the frame with no done.
- A symbol transfers on any cycle with sym_valid & sym_ready. sym_data and sym_k stay stable while sym_valid=1 and sym_ready=0.
- State machine: IDLE -> COMMA -> HEADER -> (DATA -> DATA ...) -> IDLE.
- IDLE:
  - sym_valid = IDLE_FILL, sym_data = K_CTRL, sym_k = 1.
  - start=1 latches comma_sel, comma_header, flit_data and flit_last, moves to COMMA, and raises busy next cycle.
  - If an idle symbol is presented and not yet accepted when start arrives, the frame still begins next cycle. Idle symbols carry no ordering guarantee.
- COMMA: presents K_SOD when sel=3, else K_CTRL, with k=1. Advances on transfer.
- HEADER: presents the latched header with k=0. On transfer, sel=3 goes to DATA with byte_idx=0; other types go to IDLE.
- DATA:
  - Presents byte byte_idx of the latched flit, LSB-first (bits [8*i+7:8*i]), with k=0.
  - byte_idx increments on each transfer.
  - On transfer with byte_idx = DATA_BYTES-1, returns to IDLE.
- Completion:
  - done pulses in the cycle after the final symbol transfer of the frame (the same edge that enters IDLE).
  - packet_done pulses in that same cycle when sel=3 and flit_last=1.
- Symbol counts: ACK/credit frame = 2 symbols; DATA frame = 2+DATA_BYTES symbols.
- Minimum latency with sym_ready held at 1:
  - start at cycle t -> comma presented at t+1 -> header at t+2.
  - Credit/ACK done at t+3.
  - DATA: last byte at t+1+DATA_BYTES+1, done one cycle later.
- Next frame: start may be accepted in the cycle done is high, since busy=0 then; back-to-back frames have no gap.
- start while busy=1: ignored, start_drop=1 next cycle, latched fields unchanged.
- byte_idx width is clog2(DATA_BYTES), minimum 1. It never wraps past DATA_BYTES-1.
- A frame is only delayed by sym_ready=0 stalls, never truncated. busy stays 1 throughout the stall.

Test Plan:
- Reset mid-frame: RST during DATA byte 2 -> next cycle sym_valid=0, busy=0, and no done or packet_done pulses.
- ACK, ready=1: start, sel=0, header=8'h5A -> symbols (BC,k1),(5A,k0); done at t+3; packet_done=0.
- DATA, flit_last=1: flit=32'hDEADBEEF, header=8'h81, ready=1 -> (3C,k1),(81,k0),(EF),(BE),(AD),(DE); done and packet_done both pulse once.
- Stall: same DATA frame with sym_ready=0 for 3 cycles on byte 1 -> sym_data holds 8'hBE all 3 cycles; sequence unchanged; done delayed by 3 cycles.
- Busy start / idle fill: start during a frame -> start_drop pulse and frame output unchanged. IDLE_FILL=1 while idle -> continuous (BC,k1) with sym_valid=1.
- Back-to-back: GRTCRED1 followed by DATA, with start in the cycle done is high -> no idle symbol between the frames.
